sata_rx_prim_dec: RTL and testbench
===================================

Name: sata_rx_prim_dec

Overview:
- Receive-side link-primitive decoder for one SATA port.
- Sits between the GTX receive word stream (rxdata_fis/rxcharisk) and the link-layer state machine.
- Classifies each 32-bit dword as data or a named primitive, strips ALIGN, and expands CONT-suppressed runs back into repeated primitives.
- It is the receive-side counterpart of the transmit path, which inserts ALIGN and emits primitives.

Parameters:
- C_ALIGN_PASS, 0, 1 = report ALIGN on prim_valid; 0 = drop it silently.
- C_ALIGN_CNT_W, 8, width of the saturating ALIGN counter.

Ports:
- clk_75m  in  1  phy clock; all logic on the rising edge.
- host_rst  in  1  synchronous, active-high reset.
- link_up  in  1  OOB complete; low forces the decoder idle.
- rxdata_fis  in  32  received dword, byte0 = [7:0].
- rxcharisk  in  4  per-byte K flag.
- data_out  out  32  registered copy of rxdata_fis.
- data_valid  out  1  data_out holds a payload dword.
- prim_code  out  5  decoded primitive.
- prim_valid  out  1  prim_code valid this cycle.
- cont_active  out  1  decoder is in the CONT-expansion state.
- prim_err  out  1  one-cycle pulse on an illegal K pattern or an illegal CONT.
- align_cnt  out  C_ALIGN_CNT_W  ALIGN count, saturating, cleared on reset or link_up low.

Behaviour:
- prim_code encoding:
  - 0 NONE, 1 ALIGN 7B4A4ABC, 2 CONT 9999AA7C, 3 SYNC B5B5957C.
  - 4 R_RDY 4A4A957C, 5 R_IP 5555B57C, 6 R_OK 3535B57C, 7 R_ERR 5656B57C.
  - 8 X_RDY 5757B57C, 9 SOF 3737B57C, 10 EOF D5D5B57C, 11 WTRM 5858B57C.
  - 12 HOLD D5D5AA7C, 13 HOLDA 9595AA7C, 14 PMREQ_P 1717B57C, 15 PMREQ_S 7575957C.
  - 16 PMACK 9595957C, 17 PMNAK F5F5957C, 18 DMAT 3636B57C.
- Input classification:
  - rxcharisk==4'b0000 -> data word.
  - rxcharisk==4'b0001 and dword matches the table -> primitive.
  - Any other rxcharisk, or an unmatched K-dword -> illegal.
- Latency: all outputs are registered, so input cycle N appears on the outputs at cycle N+1.
- Reset, or link_up low (sampled at cycle N, applied at N+1):
  - data_out=0, data_valid=0, prim_code=0, prim_valid=0, cont_active=0, prim_err=0, align_cnt=0.
  - state=NORM, last_prim=NONE.
- Repeatable primitives: SYNC, R_RDY, R_IP, R_OK, R_ERR, X_RDY, WTRM, HOLD, HOLDA, PMREQ_P, PMREQ_S, PMACK, PMNAK, DMAT. Not repeatable: ALIGN, CONT, SOF, EOF.
- State NORM:
  - Data word -> data_valid=1, data_out=word, prim_valid=0, last_prim=NONE.
  - Primitive other than ALIGN/CONT -> prim_valid=1, prim_code=code, last_prim=code.
  - ALIGN -> align_cnt+1 (saturating at all ones). If C_ALIGN_PASS, prim_valid=1 with code 1; otherwise all valids are 0. last_prim unchanged.
  - CONT with repeatable last_prim -> go to CONT. This cycle outputs prim_valid=1, prim_code=last_prim, cont_active=1.
  - CONT with non-repeatable last_prim or NONE -> prim_err=1, valids 0, stay in NORM.
  - Illegal word -> prim_err=1, valids 0, last_prim unchanged.
- State CONT:
  - Data word (scrambled junk) -> prim_valid=1, prim_code=last_prim, data_valid=0, cont_active=1.
  - CONT -> same as a data word in this state.
  - ALIGN -> handled as in NORM, except that with C_ALIGN_PASS=0 the output is prim_valid=1 with last_prim, so the repeated-primitive stream has no gap. cont_active stays 1.
  - Any other primitive P -> go to NORM. Output prim_valid=1, prim_code=P, cont_active=0, last_prim=P.
  - Illegal word -> prim_err=1, go to NORM, last_prim=NONE, valids 0.
- Exclusivity: data_valid and prim_valid are never both 1; prim_err is never 1 together with either of them.
- link_up falling while in CONT -> return to NORM on the next cycle with all outputs at their reset values.

Test Plan:
- Reset, then link_up=1; data 0x12345678 with charisk 0 -> next cycle: data_valid=1, data_out=0x12345678, prim_valid=0, prim_err=0.
- SYNC, SYNC, CONT, 0xA5A5A5A5, 0x3C3C3C3C, X_RDY -> prim_code sequence 3,3,3,3,3,8; cont_active=1 on cycles 3-5 and 0 on cycle 6; data_valid=0 throughout.
- C_ALIGN_PASS=0: ALIGN, ALIGN, R_RDY, CONT, ALIGN, junk ->
  - cycles 1-2: no valids.
  - R_RDY: prim_code=4.
  - CONT, ALIGN, junk: each prim_code=4 with cont_active=1.
  - align_cnt=3.
- SOF, CONT -> SOF reports code 9; CONT produces prim_err=1 pulse, state remains NORM, cont_active=0.
- Illegal inputs: dword 0x0000BC00 with charisk 0010 -> prim_err=1, no valids. Then 300 ALIGNs with C_ALIGN_CNT_W=8 -> align_cnt saturates at 255.
- HOLD, CONT, junk, then link_up=0 for 1 cycle -> all outputs return to reset values the next cycle. Then link_up=1 and CONT -> prim_err=1, because last_prim was cleared to NONE.

Source files
------------

// File: rtl/sata_rx_prim_dec.sv
// Receive-side SATA link-primitive decoder: classifies each dword as data or a named
// primitive, drops or reports ALIGN, and expands CONT-suppressed runs into repeats.
module sata_rx_prim_dec #(
  parameter int C_ALIGN_PASS  = 0,
  parameter int C_ALIGN_CNT_W = 8
) (
  input  logic                     clk_75m,
  input  logic                     host_rst,
  input  logic                     link_up,
  input  logic [31:0]              rxdata_fis,
  input  logic [3:0]               rxcharisk,
  output logic [31:0]              data_out,
  output logic                     data_valid,
  output logic [4:0]               prim_code,
  output logic                     prim_valid,
  output logic                     cont_active,
  output logic                     prim_err,
  output logic [C_ALIGN_CNT_W-1:0] align_cnt
);

  typedef enum logic {ST_NORM, ST_CONT} state_t;

  localparam logic [4:0] P_NONE  = 5'd0;
  localparam logic [4:0] P_ALIGN = 5'd1;
  localparam logic [4:0] P_CONT  = 5'd2;
  localparam logic [4:0] P_SOF   = 5'd9;
  localparam logic [4:0] P_EOF   = 5'd10;

  function automatic logic [4:0] decode_k(input logic [31:0] w);
    case (w)
      32'h7B4A4ABC: decode_k = 5'd1;
      32'h9999AA7C: decode_k = 5'd2;
      32'hB5B5957C: decode_k = 5'd3;
      32'h4A4A957C: decode_k = 5'd4;
      32'h5555B57C: decode_k = 5'd5;
      32'h3535B57C: decode_k = 5'd6;
      32'h5656B57C: decode_k = 5'd7;
      32'h5757B57C: decode_k = 5'd8;
      32'h3737B57C: decode_k = 5'd9;
      32'hD5D5B57C: decode_k = 5'd10;
      32'h5858B57C: decode_k = 5'd11;
      32'hD5D5AA7C: decode_k = 5'd12;
      32'h9595AA7C: decode_k = 5'd13;
      32'h1717B57C: decode_k = 5'd14;
      32'h7575957C: decode_k = 5'd15;
      32'h9595957C: decode_k = 5'd16;
      32'hF5F5957C: decode_k = 5'd17;
      32'h3636B57C: decode_k = 5'd18;
      default:      decode_k = P_NONE;
    endcase
  endfunction

  state_t                   state_q, state_d;
  logic [4:0]               last_prim_q, last_prim_d;
  logic [31:0]              data_out_d;
  logic                     data_valid_d, prim_valid_d, cont_active_d, prim_err_d;
  logic [4:0]               prim_code_d;
  logic [C_ALIGN_CNT_W-1:0] align_cnt_d, align_inc;
  logic [4:0]               word_code;
  logic                     is_data, is_prim, last_rep;

  assign word_code = decode_k(rxdata_fis);
  assign is_data   = (rxcharisk == 4'b0000);
  assign is_prim   = (rxcharisk == 4'b0001) && (word_code != P_NONE);
  // ALIGN, CONT, SOF, EOF and NONE can never be the subject of a CONT run.
  assign last_rep  = !(last_prim_q inside {P_NONE, P_ALIGN, P_CONT, P_SOF, P_EOF});
  assign align_inc = (&align_cnt) ? align_cnt : align_cnt + C_ALIGN_CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    last_prim_d   = last_prim_q;
    data_out_d    = rxdata_fis;
    data_valid_d  = 1'b0;
    prim_valid_d  = 1'b0;
    prim_code_d   = P_NONE;
    cont_active_d = 1'b0;
    prim_err_d    = 1'b0;
    align_cnt_d   = align_cnt;
    case (state_q)
      ST_NORM: begin
        if (is_data) begin
          data_valid_d = 1'b1;
          last_prim_d  = P_NONE;
        end else if (is_prim && word_code == P_ALIGN) begin
          align_cnt_d = align_inc;
          if (C_ALIGN_PASS != 0) begin
            prim_valid_d = 1'b1;
            prim_code_d  = P_ALIGN;
          end
        end else if (is_prim && word_code == P_CONT) begin
          if (last_rep) begin
            state_d       = ST_CONT;
            prim_valid_d  = 1'b1;
            prim_code_d   = last_prim_q;
            cont_active_d = 1'b1;
          end else begin
            prim_err_d = 1'b1;
          end
        end else if (is_prim) begin
          prim_valid_d = 1'b1;
          prim_code_d  = word_code;
          last_prim_d  = word_code;
        end else begin
          prim_err_d = 1'b1;
        end
      end
      ST_CONT: begin
        // Scrambled filler and repeated CONTs both keep the expanded stream going.
        if (is_data || (is_prim && word_code == P_CONT)) begin
          prim_valid_d  = 1'b1;
          prim_code_d   = last_prim_q;
          cont_active_d = 1'b1;
        end else if (is_prim && word_code == P_ALIGN) begin
          align_cnt_d   = align_inc;
          prim_valid_d  = 1'b1;
          prim_code_d   = (C_ALIGN_PASS != 0) ? P_ALIGN : last_prim_q;
          cont_active_d = 1'b1;
        end else if (is_prim) begin
          state_d      = ST_NORM;
          prim_valid_d = 1'b1;
          prim_code_d  = word_code;
          last_prim_d  = word_code;
        end else begin
          state_d     = ST_NORM;
          prim_err_d  = 1'b1;
          last_prim_d = P_NONE;
        end
      end
      default: state_d = ST_NORM;
    endcase
  end

  // cont_active is the registered state and doubles as the FSM's visible state.
  always_ff @(posedge clk_75m) begin
    if (host_rst || !link_up) begin
      state_q     <= ST_NORM;
      last_prim_q <= P_NONE;
      data_out    <= '0;
      data_valid  <= 1'b0;
      prim_code   <= P_NONE;
      prim_valid  <= 1'b0;
      cont_active <= 1'b0;
      prim_err    <= 1'b0;
      align_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      last_prim_q <= last_prim_d;
      data_out    <= data_out_d;
      data_valid  <= data_valid_d;
      prim_code   <= prim_code_d;
      prim_valid  <= prim_valid_d;
      cont_active <= cont_active_d;
      prim_err    <= prim_err_d;
      align_cnt   <= align_cnt_d;
    end
  end

endmodule

// File: tb/tb_sata_rx_prim_dec.sv
// Directed bench for sata_rx_prim_dec with ALIGN dropped and an 8-bit ALIGN counter.
module tb_sata_rx_prim_dec;

  localparam logic [31:0] W_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] W_CONT  = 32'h9999AA7C;
  localparam logic [31:0] W_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] W_R_RDY = 32'h4A4A957C;
  localparam logic [31:0] W_X_RDY = 32'h5757B57C;
  localparam logic [31:0] W_SOF   = 32'h3737B57C;
  localparam logic [31:0] W_HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] W_HOLDA = 32'h9595AA7C;

  logic        clk_75m = 1'b0;
  logic        host_rst, link_up;
  logic [31:0] rxdata_fis;
  logic [3:0]  rxcharisk;
  logic [31:0] data_out;
  logic        data_valid, prim_valid, cont_active, prim_err;
  logic [4:0]  prim_code;
  logic [7:0]  align_cnt;

  int checks   = 0;
  int failures = 0;

  sata_rx_prim_dec #(.C_ALIGN_PASS(0), .C_ALIGN_CNT_W(8)) dut (
    .clk_75m(clk_75m), .host_rst(host_rst), .link_up(link_up),
    .rxdata_fis(rxdata_fis), .rxcharisk(rxcharisk),
    .data_out(data_out), .data_valid(data_valid),
    .prim_code(prim_code), .prim_valid(prim_valid),
    .cont_active(cont_active), .prim_err(prim_err), .align_cnt(align_cnt)
  );

  always #5 clk_75m = ~clk_75m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the handshake outputs; prim_code only when a primitive is expected.
  task automatic chk_ctl(input string tag, input logic dv, input logic pv,
                         input logic [4:0] pc, input logic ca, input logic pe);
    chk({tag, ".data_valid"}, 32'(data_valid), 32'(dv));
    chk({tag, ".prim_valid"}, 32'(prim_valid), 32'(pv));
    if (pv) chk({tag, ".prim_code"}, 32'(prim_code), 32'(pc));
    chk({tag, ".cont_active"}, 32'(cont_active), 32'(ca));
    chk({tag, ".prim_err"}, 32'(prim_err), 32'(pe));
  endtask

  // Present one dword, then sample 1 time unit after the edge that registered it.
  task automatic send(input logic [31:0] w, input logic [3:0] k);
    rxdata_fis = w;
    rxcharisk  = k;
    @(posedge clk_75m);
    #1;
  endtask

  task automatic do_reset();
    host_rst = 1'b1;
    send(32'h0, 4'b0000);
    send(32'h0, 4'b0000);
    host_rst = 1'b0;
  endtask

  initial begin
    host_rst   = 1'b1;
    link_up    = 1'b0;
    rxdata_fis = 32'h0;
    rxcharisk  = 4'b0000;
    do_reset();
    chk_ctl("reset", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("reset.prim_code", 32'(prim_code), 32'd0);
    chk("reset.data_out", data_out, 32'h0);
    chk("reset.align_cnt", 32'(align_cnt), 32'd0);
    link_up = 1'b1;

    send(32'h12345678, 4'b0000);
    chk_ctl("data", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("data.data_out", data_out, 32'h12345678);

    send(W_SYNC, 4'b0001);        chk_ctl("sync1", 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    send(W_SYNC, 4'b0001);        chk_ctl("sync2", 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    send(W_CONT, 4'b0001);        chk_ctl("sync_cont", 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
    send(32'hA5A5A5A5, 4'b0000);  chk_ctl("sync_junk1", 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
    send(32'h3C3C3C3C, 4'b0000);  chk_ctl("sync_junk2", 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
    send(W_X_RDY, 4'b0001);       chk_ctl("x_rdy", 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);

    do_reset();
    send(W_ALIGN, 4'b0001);       chk_ctl("align1", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    send(W_ALIGN, 4'b0001);       chk_ctl("align2", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    send(W_R_RDY, 4'b0001);       chk_ctl("r_rdy", 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
    send(W_CONT, 4'b0001);        chk_ctl("r_rdy_cont", 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
    send(W_ALIGN, 4'b0001);       chk_ctl("cont_align", 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
    send(32'h11223344, 4'b0000);  chk_ctl("cont_junk", 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
    chk("align_cnt3", 32'(align_cnt), 32'd3);
    send(W_SYNC, 4'b0001);        chk_ctl("cont_exit", 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);

    send(W_SOF, 4'b0001);         chk_ctl("sof", 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    send(W_CONT, 4'b0001);        chk_ctl("sof_cont", 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    send(32'hCAFEF00D, 4'b0000);  chk_ctl("err_pulse", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

    send(32'h0000BC00, 4'b0010);  chk_ctl("bad_k", 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    send(32'h0000007C, 4'b0001);  chk_ctl("bad_kword", 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) send(W_ALIGN, 4'b0001);
    chk("align_sat", 32'(align_cnt), 32'd255);
    chk_ctl("align_sat_ctl", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    send(W_HOLDA, 4'b0001);       chk_ctl("holda", 1'b0, 1'b1, 5'd13, 1'b0, 1'b0);
    send(W_CONT, 4'b0001);        chk_ctl("holda_cont", 1'b0, 1'b1, 5'd13, 1'b1, 1'b0);
    send(32'h0, 4'b1111);         chk_ctl("cont_bad", 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    send(W_CONT, 4'b0001);        chk_ctl("cont_after_bad", 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

    send(W_HOLD, 4'b0001);        chk_ctl("hold", 1'b0, 1'b1, 5'd12, 1'b0, 1'b0);
    send(W_CONT, 4'b0001);        chk_ctl("hold_cont", 1'b0, 1'b1, 5'd12, 1'b1, 1'b0);
    send(32'h5A5A5A5A, 4'b0000);  chk_ctl("hold_junk", 1'b0, 1'b1, 5'd12, 1'b1, 1'b0);
    link_up = 1'b0;
    send(32'h77777777, 4'b0000);
    chk_ctl("link_down", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("link_down.prim_code", 32'(prim_code), 32'd0);
    chk("link_down.data_out", data_out, 32'h0);
    chk("link_down.align_cnt", 32'(align_cnt), 32'd0);
    link_up = 1'b1;
    send(W_CONT, 4'b0001);        chk_ctl("relink_cont", 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
